// File: rtl/rv32i_pkg.sv
// Shared RV32I constants, opcode encodings and the fetch-stage state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32i_pkg;

   localparam int          XLEN_DEFAULT     = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      ERROR = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with push, pop, flush and an occupancy count.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_dat,
   input  logic                       pop,
   input  logic                       flush,
   output logic [WIDTH-1:0]           head_dat,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW-1:0]    wr_q, wr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // Next pointers/count; flush discards everything including a same-cycle push.
   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      do_pop  = pop && (cnt_q != '0);
      do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_q] = push_dat;
            wr_d        = ptr_inc(wr_q);
         end
         if (do_pop) begin
            rd_d = ptr_inc(rd_q);
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_dat = mem_q[rd_q];
   assign count    = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, requests imem words, buffers responses for decode.
// Latency: an instruction is presented the cycle after its imem response.
// Backpressure: requests stall while outstanding + buffered reaches DEPTH; decode stalls via instr_ready.
module fetch_stage #(
   parameter int              XLEN     = rv32i_pkg::XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv32i_pkg::RESET_PC_DEFAULT),
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4,
   output logic [6:0]      op_code,
   output logic [2:0]      func3,
   output logic [6:0]      func7,
   output logic            fetch_misaligned
);
   import rv32i_pkg::*;

   localparam int CW = $clog2(DEPTH + 1);
   localparam int FW = 32 + XLEN;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [CW-1:0]   stale_q, stale_d;
   logic            misaligned_q, misaligned_d;

   // The PC-tag queue holds exactly the accepted-but-unanswered requests,
   // so its occupancy is the outstanding count.
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   out_next;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     inflight;
   logic [FW-1:0]   fifo_head;
   logic [XLEN-1:0] tag_head;
   logic            req_vld, req_acc;
   logic            rsp_keep, fifo_flush, fifo_pop;

   // Issue decision: no request in BOOT/ERROR, in a redirect cycle, or when the budget is used up.
   always_comb begin
      inflight = {1'b0, outstanding} + {1'b0, fifo_count};
      req_vld  = (state_q == RUN) && !redirect_valid && (inflight < (CW+1)'(DEPTH));
      req_acc  = req_vld && imem_req_ready;
   end

   // Next-state logic for the FSM, PC, stale counter and error flag.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      stale_d      = stale_q;
      misaligned_d = misaligned_q;
      rsp_keep     = 1'b0;
      fifo_flush   = 1'b0;
      out_next     = outstanding + CW'(req_acc) - CW'(imem_rsp_valid);
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (req_acc) begin
               pc_d = pc_q + XLEN'(4);
            end
            if (imem_rsp_valid) begin
               if (stale_q != '0) begin
                  stale_d = stale_q - CW'(1);
               end else begin
                  rsp_keep = 1'b1;
               end
            end
            if (redirect_valid) begin
               // Everything still in flight (and this cycle's response) belongs to the old path.
               fifo_flush = 1'b1;
               rsp_keep   = 1'b0;
               if (redirect_target[1:0] == 2'b00) begin
                  pc_d    = redirect_target;
                  stale_d = out_next;
               end else begin
                  misaligned_d = 1'b1;
                  state_d      = ERROR;
               end
            end
         end
         ERROR: begin
            // Sticky until reset; responses are absorbed by the tag queue and dropped.
            state_d = ERROR;
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= BOOT;
         pc_q         <= RESET_PC;
         stale_q      <= '0;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         stale_q      <= stale_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign fifo_pop = instr_valid && instr_ready;

   sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (req_acc),
      .push_dat (pc_q),
      .pop      (imem_rsp_valid),
      .flush    (1'b0),
      .head_dat (tag_head),
      .count    (outstanding)
   );

   sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH)) u_instr_q (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (rsp_keep),
      .push_dat ({imem_rsp_data, tag_head}),
      .pop      (fifo_pop),
      .flush    (fifo_flush),
      .head_dat (fifo_head),
      .count    (fifo_count)
   );

   assign imem_req_valid   = req_vld;
   assign imem_req_addr    = pc_q;
   assign instr_valid      = (fifo_count != '0);
   assign instr            = instr_valid ? fifo_head[FW-1:XLEN] : 32'h0;
   assign instr_pc         = instr_valid ? fifo_head[XLEN-1:0] : '0;
   assign instr_pc_plus4   = instr_pc + XLEN'(4);
   assign op_code          = instr[6:0];
   assign func3            = instr[14:12];
   assign func7            = instr[31:25];
   assign fetch_misaligned = misaligned_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_target = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;
   logic [6:0]  op_code;
   logic [2:0]  func3;
   logic [6:0]  func7;
   logic        fetch_misaligned;

   int checks = 0;
   int errors = 0;
   int lat = 1;
   int own_out = 0;
   int cyc = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] req_log[$];
   logic [31:0] log_pc[$];
   logic [31:0] log_instr[$];
   logic [31:0] log_p4[$];

   fetch_stage dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem_req_valid   (imem_req_valid),
      .imem_req_ready   (imem_req_ready),
      .imem_req_addr    (imem_req_addr),
      .imem_rsp_valid   (imem_rsp_valid),
      .imem_rsp_data    (imem_rsp_data),
      .redirect_valid   (redirect_valid),
      .redirect_target  (redirect_target),
      .instr_valid      (instr_valid),
      .instr_ready      (instr_ready),
      .instr            (instr),
      .instr_pc         (instr_pc),
      .instr_pc_plus4   (instr_pc_plus4),
      .op_code          (op_code),
      .func3            (func3),
      .func7            (func7),
      .fetch_misaligned (fetch_misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0000_2003;
      return {a[24:0], 7'b0010011};
   endfunction

   task automatic apply_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      redirect_target = 32'h0;
      instr_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'h0;
      pend_addr.delete(); pend_due.delete(); req_log.delete();
      log_pc.delete(); log_instr.delete(); log_p4.delete();
      own_out = 0;
      cyc = 0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: record handshakes before the edge, then drive the next memory response.
   task automatic tick();
      logic acc, hs, rv;
      logic [31:0] a;
      #1;
      acc = imem_req_valid && imem_req_ready;
      hs  = instr_valid && instr_ready;
      rv  = imem_rsp_valid;
      a   = imem_req_addr;
      if (acc) req_log.push_back(a);
      if (hs) begin
         log_pc.push_back(instr_pc);
         log_instr.push_back(instr);
         log_p4.push_back(instr_pc_plus4);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (rv) own_out--;
      if (acc) begin
         own_out++;
         pend_addr.push_back(a);
         pend_due.push_back(cyc + lat - 1);
         checks++;
         if (own_out > DEPTH) begin
            errors++;
            $display("FAIL outstanding_cap: got %0d expected <= %0d", own_out, DEPTH);
         end
      end
      if (pend_addr.size() != 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = imem_word(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
      checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", fetch_misaligned); end
      checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 00000000", imem_req_addr); end
      checks++; if (op_code !== 7'h0) begin errors++; $display("FAIL reset_op_code: got %b expected 0000000", op_code); end
   endtask

   task automatic test_basic();
      int bad;
      lat = 1;
      apply_reset();
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL boot_no_req: got %b expected 0", imem_req_valid); end
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL first_req: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); end
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4 || instr_valid !== 1'b0) begin errors++; $display("FAIL second_req: got v=%b a=%h iv=%b expected v=1 a=00000004 iv=0", imem_req_valid, imem_req_addr, instr_valid); end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h0000_2003) begin errors++; $display("FAIL first_instr: got v=%b pc=%h i=%h expected v=1 pc=00000000 i=00002003", instr_valid, instr_pc, instr); end
      checks++; if (op_code !== 7'b0000011 || func3 !== 3'b010 || func7 !== 7'b0) begin errors++; $display("FAIL first_fields: got op=%b f3=%b f7=%b expected op=0000011 f3=010 f7=0000000", op_code, func3, func7); end
      checks++; if (instr_pc_plus4 !== 32'h4) begin errors++; $display("FAIL first_plus4: got %h expected 00000004", instr_pc_plus4); end
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL budget_full: got %b expected 0", imem_req_valid); end
      repeat (12) tick();
      bad = 0;
      for (int i = 0; i < 3; i++) if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL req_sequence: got %0d bad of first 3 addresses, expected 0", bad); end
   endtask

   task automatic test_backpressure();
      int bad;
      lat = 1;
      apply_reset();
      instr_ready = 1'b0;
      repeat (10) tick();
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stall: got %b expected 0", imem_req_valid); end
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=00000000", instr_valid, instr_pc); end
      checks++; if (req_log.size() != 2) begin errors++; $display("FAIL bp_req_count: got %0d expected 2", req_log.size()); end
      instr_ready = 1'b1;
      repeat (20) tick();
      checks++; if (log_pc.size() < 8) begin errors++; $display("FAIL bp_progress: got %0d instrs expected >= 8", log_pc.size()); end
      bad = 0;
      foreach (log_pc[i]) if (log_pc[i] !== 32'(4 * i) || log_instr[i] !== imem_word(32'(4 * i))) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_order: got %0d out-of-sequence instrs expected 0", bad); end
   endtask

   task automatic test_redirect_stale();
      int n, bad, k;
      lat = 3;
      apply_reset();
      k = 0;
      while (req_log.size() < 4 && k < 40) begin tick(); k++; end
      checks++; if (req_log.size() != 4 || own_out != 2) begin errors++; $display("FAIL stale_setup: got reqs=%0d out=%0d expected reqs=4 out=2", req_log.size(), own_out); end
      redirect_valid = 1'b1;
      redirect_target = 32'h100;
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redirect_no_req: got %b expected 0", imem_req_valid); end
      tick();
      redirect_valid = 1'b0;
      n = log_pc.size();
      k = 0;
      while (log_pc.size() == n && k < 30) begin tick(); k++; end
      checks++; if (log_pc.size() == n || log_pc[n] !== 32'h100 || log_instr[n] !== imem_word(32'h100)) begin errors++; $display("FAIL stale_target: got %0d new instrs, first pc=%h expected pc=00000100", log_pc.size() - n, (log_pc.size() > n) ? log_pc[n] : 32'hx); end
      checks++; if (req_log.size() < 5 || req_log[4] !== 32'h100) begin errors++; $display("FAIL stale_next_req: got %0d reqs expected 5th addr 00000100", req_log.size()); end
      repeat (10) tick();
      bad = 0;
      foreach (log_pc[i]) if (log_pc[i] == 32'h8 || log_pc[i] == 32'hC) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL stale_dropped: got %0d stale instrs presented expected 0", bad); end
   endtask

   task automatic test_redirect_pop_full();
      int k;
      lat = 1;
      apply_reset();
      instr_ready = 1'b0;
      repeat (8) tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_setup: got v=%b pc=%h rv=%b expected v=1 pc=00000000 rv=0", instr_valid, instr_pc, imem_req_valid); end
      instr_ready = 1'b1;
      redirect_valid = 1'b1;
      redirect_target = 32'h200;
      tick();
      redirect_valid = 1'b0;
      checks++; if (log_pc.size() != 1 || log_pc[0] !== 32'h0) begin errors++; $display("FAIL full_head_once: got %0d transfers expected 1 at pc 00000000", log_pc.size()); end
      k = 0;
      while (log_pc.size() < 2 && k < 30) begin tick(); k++; end
      checks++; if (log_pc.size() < 2 || log_pc[1] !== 32'h200) begin errors++; $display("FAIL full_next_target: got %0d transfers, second pc=%h expected 00000200", log_pc.size(), (log_pc.size() > 1) ? log_pc[1] : 32'hx); end
   endtask

   task automatic test_misaligned();
      int bad;
      lat = 1;
      apply_reset();
      repeat (5) tick();
      redirect_valid = 1'b1;
      redirect_target = 32'h102;
      tick();
      redirect_valid = 1'b0;
      checks++; if (fetch_misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_flag: got %b expected 1", fetch_misaligned); end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL error_quiet: got %0d active cycles expected 0", bad); end
      rst_n = 1'b0;
      #1;
      checks++; if (fetch_misaligned !== 1'b0) begin errors++; $display("FAIL misaligned_clear: got %b expected 0", fetch_misaligned); end
      apply_reset();
      tick();
      checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin errors++; $display("FAIL restart_pc: got v=%b a=%h expected v=1 a=00000000", imem_req_valid, imem_req_addr); end
   endtask

   task automatic test_async_reset();
      int k;
      lat = 1;
      apply_reset();
      k = 0;
      while (!(instr_valid === 1'b1 && imem_req_valid === 1'b1) && k < 20) begin tick(); k++; end
      checks++; if (instr_valid !== 1'b1 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL async_setup: got iv=%b rv=%b expected 1 1", instr_valid, imem_req_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL async_clear: got iv=%b rv=%b expected 0 0", instr_valid, imem_req_valid); end
   endtask

   task automatic test_wrap();
      int rn, ln;
      lat = 1;
      apply_reset();
      repeat (4) tick();
      redirect_valid = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      rn = req_log.size();
      ln = log_pc.size();
      repeat (15) tick();
      checks++; if (req_log.size() < rn + 2 || req_log[rn] !== 32'hFFFF_FFFC || req_log[rn + 1] !== 32'h0) begin errors++; $display("FAIL wrap_req: got %0d reqs after redirect expected FFFFFFFC then 00000000", req_log.size() - rn); end
      checks++; if (log_pc.size() < ln + 1 || log_pc[ln] !== 32'hFFFF_FFFC || log_p4[ln] !== 32'h0) begin errors++; $display("FAIL wrap_plus4: got pc=%h p4=%h expected pc=FFFFFFFC p4=00000000", (log_pc.size() > ln) ? log_pc[ln] : 32'hx, (log_p4.size() > ln) ? log_p4[ln] : 32'hx); end
      checks++; if (log_pc.size() < ln + 2 || log_pc[ln + 1] !== 32'h0 || log_p4[ln + 1] !== 32'h4) begin errors++; $display("FAIL wrap_next: got %0d instrs after redirect expected second pc=00000000 p4=00000004", log_pc.size() - ln); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect_stale();
      test_redirect_pop_full();
      test_misaligned();
      test_async_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
